// File: rtl/msx_arb_pkg.sv
// msx_arb_pkg: shared arbiter state and grant encodings plus a saturating counter helper
package msx_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CPU_ACC, S_LD_ACC, S_CPU_HOLD} arb_state_e;
  typedef enum logic [1:0] {GNT_NONE, GNT_CPU, GNT_LD} arb_gnt_e;
  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction
endpackage

// File: rtl/arb_ld_buffer.sv
// arb_ld_buffer: one-entry loader holding register with overflow flag and consume-and-refill
module arb_ld_buffer #(
  parameter int unsigned ADDR_W = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_wr,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_din,
  input  logic              consume,
  output logic              full,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [7:0]        buf_din,
  output logic              ovf
);
  logic              full_q, full_d, ovf_q, ovf_d, accept;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        din_q, din_d;
  always_comb begin
    accept = ld_wr & (~full_q | consume);
    full_d = accept | (full_q & ~consume);
    ovf_d  = ovf_q | (ld_wr & full_q & ~consume);
    addr_d = accept ? ld_addr : addr_q;
    din_d  = accept ? ld_din : din_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      full_q <= full_d;
      ovf_q  <= ovf_d;
      addr_q <= addr_d;
      din_q  <= din_d;
    end
  end
  assign full     = full_q;
  assign ovf      = ovf_q;
  assign buf_addr = addr_q;
  assign buf_din  = din_q;
endmodule

// File: rtl/cart_mem_arbiter.sv
// cart_mem_arbiter: shares the cartridge memory port between the Z80 slot path and the ioctl loader
module cart_mem_arbiter
  import msx_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 25,
  parameter int unsigned LOADER_PRIO = 1,
  parameter int unsigned MAX_CONSEC  = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_wait_n,
  input  logic              ld_wr,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_din,
  output logic              ld_wait,
  output logic              ld_ovf,
  output logic              to_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic              mem_ack,
  input  logic [7:0]        mem_dout
);
  arb_state_e        state_q, state_d;
  arb_gnt_e          gnt;
  logic              rise, cpu_go, starve, in_acc, expire, done, cpu_done, ld_done;
  logic              cpu_req_q, cpu_pend_q, cpu_pend_d, cpu_we_q, cpu_we_d;
  logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
  logic [7:0]        cpu_din_q, cpu_din_d, cpu_dout_q, cpu_dout_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_din_q, mem_din_d;
  logic              to_err_q, to_err_d;
  logic [3:0]        consec_q, consec_d;
  logic [7:0]        timer_q, timer_d;
  logic              ld_full;
  logic [ADDR_W-1:0] ld_buf_addr;
  logic [7:0]        ld_buf_din;
  arb_ld_buffer #(.ADDR_W(ADDR_W)) u_ld_buf (
    .clk      (clk),
    .reset    (reset),
    .ld_wr    (ld_wr),
    .ld_addr  (ld_addr),
    .ld_din   (ld_din),
    .consume  (ld_done),
    .full     (ld_full),
    .buf_addr (ld_buf_addr),
    .buf_din  (ld_buf_din),
    .ovf      (ld_ovf)
  );
  always_comb begin
    rise       = cpu_req & ~cpu_req_q;
    cpu_go     = cpu_pend_q & cpu_req;
    starve     = cpu_go & (consec_q == 4'(MAX_CONSEC));
    gnt        = (ld_full & ((LOADER_PRIO != 0) | ~cpu_go) & ~starve) ? GNT_LD : cpu_go ? GNT_CPU : GNT_NONE;
    in_acc     = (state_q == S_CPU_ACC) | (state_q == S_LD_ACC);
    expire     = in_acc & ~mem_ack & (timer_q == 8'(TIMEOUT));
    done       = in_acc & (mem_ack | expire);
    cpu_done   = done & (state_q == S_CPU_ACC);
    ld_done    = done & (state_q == S_LD_ACC);
    cpu_pend_d = rise | (cpu_pend_q & ~cpu_done & (cpu_req | (state_q == S_CPU_ACC)));
    cpu_we_d   = rise ? cpu_we : cpu_we_q;
    cpu_addr_d = rise ? cpu_addr : cpu_addr_q;
    cpu_din_d  = rise ? cpu_din : cpu_din_q;
    cpu_dout_d = (cpu_done & cpu_req & ~mem_we_q) ? (expire ? 8'hFF : mem_dout) : cpu_dout_q;
    timer_d    = (in_acc & ~done) ? timer_q + 8'd1 : 8'd0;
    to_err_d   = to_err_q | expire;
    consec_d   = cpu_done ? 4'd0 : ld_done ? (cpu_pend_q ? sat_inc(consec_q, 4'(MAX_CONSEC)) : 4'd0) : consec_q;
    mem_req_d  = mem_req_q & ~done;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    state_d    = state_q;
    if ((state_q == S_IDLE) && (gnt != GNT_NONE)) begin
      state_d    = (gnt == GNT_CPU) ? S_CPU_ACC : S_LD_ACC;
      mem_req_d  = 1'b1;
      mem_we_d   = (gnt == GNT_CPU) ? cpu_we_q : 1'b1;
      mem_addr_d = (gnt == GNT_CPU) ? cpu_addr_q : ld_buf_addr;
      mem_din_d  = (gnt == GNT_CPU) ? cpu_din_q : ld_buf_din;
    end
    if (cpu_done) state_d = cpu_req ? S_CPU_HOLD : S_IDLE;
    if (ld_done) state_d = S_IDLE;
    if ((state_q == S_CPU_HOLD) && !cpu_req) state_d = S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cpu_req_q  <= 1'b0;
      cpu_pend_q <= 1'b0;
      cpu_we_q   <= 1'b0;
      cpu_addr_q <= '0;
      cpu_din_q  <= '0;
      cpu_dout_q <= 8'hFF;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      to_err_q   <= 1'b0;
      consec_q   <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      cpu_req_q  <= cpu_req;
      cpu_pend_q <= cpu_pend_d;
      cpu_we_q   <= cpu_we_d;
      cpu_addr_q <= cpu_addr_d;
      cpu_din_q  <= cpu_din_d;
      cpu_dout_q <= cpu_dout_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      to_err_q   <= to_err_d;
      consec_q   <= consec_d;
      timer_q    <= timer_d;
    end
  end
  assign cpu_wait_n = reset | ~(cpu_req & (cpu_pend_q | (state_q == S_CPU_ACC) | ~cpu_req_q));
  assign cpu_dout   = cpu_dout_q;
  assign ld_wait    = ld_full;
  assign to_err     = to_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
endmodule

// File: tb/tb_cart_mem_arbiter.sv
// tb_cart_mem_arbiter: directed scenarios plus randomized traffic against a memory-content reference model
module tb_cart_mem_arbiter;
  localparam int AW = 25;
  logic          clk = 1'b0;
  logic          reset, cpu_req, cpu_we, ld_wr, mem_ack;
  logic [AW-1:0] cpu_addr, ld_addr;
  logic [7:0]    cpu_din, ld_din, mem_dout;
  logic [7:0]    cpu_dout, mem_din;
  logic          cpu_wait_n, ld_wait, ld_ovf, to_err, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  int            n_chk = 0, n_fail = 0;
  bit            resp_en = 1'b0;
  int            resp_min = 1, resp_max = 1, stray_req = 0;
  int            stab_err = 0, req_rises = 0;
  bit            log_we[$];
  int            log_addr[$];
  logic [7:0]    mem_model [int];

  cart_mem_arbiter #(.ADDR_W(AW), .LOADER_PRIO(1), .MAX_CONSEC(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_wait_n(cpu_wait_n), .ld_wr(ld_wr),
    .ld_addr(ld_addr), .ld_din(ld_din), .ld_wait(ld_wait), .ld_ovf(ld_ovf), .to_err(to_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_ack(mem_ack), .mem_dout(mem_dout)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [7:0] seed(input int a);
    logic [31:0] v;
    v = a;
    return v[7:0] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] rd(input int a);
    return mem_model.exists(a) ? mem_model[a] : seed(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  // SDRAM stand-in: acks after a random latency, stores writes, returns stored or seeded data
  initial begin
    bit busy = 1'b0, acked = 1'b0, cw = 1'b0;
    int wl = 0, seen = 0;
    logic [AW-1:0] ca = '0;
    logic [7:0] cd = '0;
    mem_ack = 1'b0;
    mem_dout = 8'h00;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (stray_req != seen) begin
        seen = stray_req;
        mem_ack = 1'b1;
      end else if (resp_en) begin
        if (!mem_req) busy = 1'b0;
        else if (!busy) begin
          busy = 1'b1;
          acked = 1'b0;
          cw = mem_we;
          ca = mem_addr;
          cd = mem_din;
          req_rises++;
          wl = $urandom_range(resp_max, resp_min);
        end else begin
          if ({mem_we, mem_addr, mem_din} !== {cw, ca, cd}) stab_err++;
          if (!acked) begin
            if (wl == 0) begin
              mem_ack = 1'b1;
              acked = 1'b1;
              log_we.push_back(cw);
              log_addr.push_back(int'(ca));
              if (cw) mem_model[int'(ca)] = cd;
              else mem_dout = rd(int'(ca));
            end else wl--;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic cpu_run(input bit we, input int a, input logic [7:0] d, input int lim, output int lows);
    int n = 0;
    lows = 0;
    cpu_we = we;
    cpu_addr = AW'(a);
    cpu_din = d;
    cpu_req = 1'b1;
    do begin
      tick;
      ld_wr = 1'b0;
      n++;
      lows += int'(!cpu_wait_n);
    end while (!cpu_wait_n && n < lim);
    chk("cpu_complete", cpu_wait_n, 1'b1);
  endtask

  task automatic cpu_end;
    cpu_req = 1'b0;
    tick;
    tick;
  endtask

  initial begin
    int lows, base, rbase, sent, idx, bad, hi, n, age, ca;
    bit cw;
    logic [7:0] cpu_ref [16];
    logic [7:0] ld_ref [16];
    bit ldw [16];
    reset = 1'b1;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_din = '0;
    ld_wr = 1'b0;
    ld_addr = '0;
    ld_din = '0;
    repeat (3) tick;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_cpu_dout", cpu_dout, 8'hFF);
    chk("rst_wait_n", cpu_wait_n, 1'b1);
    chk("rst_ld_wait", ld_wait, 1'b0);
    chk("rst_ld_ovf", ld_ovf, 1'b0);
    chk("rst_to_err", to_err, 1'b0);
    cpu_req = 1'b0;
    tick;
    reset = 1'b0;
    tick;
    // single CPU read
    resp_en = 1'b1;
    resp_min = 3;
    resp_max = 3;
    rbase = req_rises;
    cpu_we = 1'b0;
    cpu_addr = AW'(32'h12FF);
    cpu_req = 1'b1;
    #1;
    chk("t1_wait_same_cycle", cpu_wait_n, 1'b0);
    cpu_run(1'b0, 32'h12FF, 8'h00, 50, lows);
    chk("t1_wait_len", lows >= 4, 1'b1);
    chk("t1_dout", cpu_dout, 8'h5A);
    chk("t1_nreq", req_rises - rbase, 1);
    cpu_end;
    // simultaneous loader write and CPU read
    base = log_we.size();
    ld_addr = AW'(32'h2000);
    ld_din = 8'h3C;
    ld_wr = 1'b1;
    cpu_run(1'b0, 32'h40, 8'h00, 60, lows);
    chk("t2_ntx", log_we.size() - base, 2);
    chk("t2_first_we", log_we[base], 1'b1);
    chk("t2_first_addr", log_addr[base], 32'h2000);
    chk("t2_second_we", log_we[base+1], 1'b0);
    chk("t2_second_addr", log_addr[base+1], 32'h40);
    chk("t2_dout", cpu_dout, seed(32'h40));
    chk("t2_memwr", rd(32'h2000), 8'h3C);
    cpu_end;
    // loader streaming with CPU pending: starvation limit
    resp_min = 1;
    resp_max = 3;
    base = log_we.size();
    sent = 1;
    ld_addr = AW'(32'h3000);
    ld_din = 8'd1;
    ld_wr = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = AW'(32'h80);
    cpu_req = 1'b1;
    n = 0;
    do begin
      tick;
      ld_wr = 1'b0;
      n++;
      if (mem_ack && mem_we && sent < 10) begin
        ld_addr = AW'(32'h3000 + sent);
        ld_din = 8'(sent * 7 + 1);
        ld_wr = 1'b1;
        sent++;
      end
      if (cpu_req && cpu_wait_n) begin
        chk("t3_dout", cpu_dout, seed(32'h80));
        cpu_req = 1'b0;
      end
    end while (!(log_we.size() - base == 11 && !mem_req && !ld_wait) && n < 500);
    idx = -1;
    for (int k = 0; k < log_we.size() - base; k++) if (idx < 0 && !log_we[base+k]) idx = k;
    chk("t3_ntx", log_we.size() - base, 11);
    chk("t3_cpu_slot", idx, 4);
    chk("t3_ovf", ld_ovf, 1'b0);
    bad = 0;
    for (int k = 0; k < 10; k++) if (rd(32'h3000 + k) !== 8'(k * 7 + 1)) bad++;
    chk("t3_data", bad, 0);
    cpu_end;
    // overflow
    resp_min = 4;
    resp_max = 4;
    ld_addr = AW'(32'h4000);
    ld_din = 8'h11;
    ld_wr = 1'b1;
    tick;
    ld_wr = 1'b0;
    chk("t4_wait", ld_wait, 1'b1);
    ld_din = 8'h22;
    ld_wr = 1'b1;
    tick;
    ld_wr = 1'b0;
    chk("t4_ovf", ld_ovf, 1'b1);
    n = 0;
    do begin tick; n++; end while ((ld_wait || mem_req) && n < 50);
    chk("t4_kept_first", rd(32'h4000), 8'h11);
    chk("t4_ovf_sticky", ld_ovf, 1'b1);
    // timeout
    resp_en = 1'b0;
    tick;
    cpu_we = 1'b0;
    cpu_addr = AW'(32'h500);
    cpu_req = 1'b1;
    n = 0;
    hi = 0;
    do begin tick; n++; hi += int'(mem_req); end while (!cpu_wait_n && n < 60);
    chk("t5_wait_release", cpu_wait_n, 1'b1);
    chk("t5_req_drop", mem_req, 1'b0);
    chk("t5_to_err", to_err, 1'b1);
    chk("t5_dout_ff", cpu_dout, 8'hFF);
    chk("t5_req_len", hi >= 8 && hi <= 9, 1'b1);
    cpu_end;
    // reset in the middle of an access, then a stray ack
    cpu_we = 1'b0;
    cpu_addr = AW'(32'h600);
    cpu_req = 1'b1;
    n = 0;
    do begin tick; n++; end while (!mem_req && n < 10);
    chk("t6_in_acc", mem_req, 1'b1);
    reset = 1'b1;
    cpu_req = 1'b0;
    tick;
    chk("t6_rst_req", mem_req, 1'b0);
    chk("t6_rst_to_err", to_err, 1'b0);
    chk("t6_rst_ovf", ld_ovf, 1'b0);
    reset = 1'b0;
    stray_req++;
    tick;
    tick;
    hi = 0;
    repeat (4) begin tick; hi += int'(mem_req); end
    chk("t6_no_req", hi, 0);
    chk("t6_addr", mem_addr, 0);
    chk("t6_dout", cpu_dout, 8'hFF);
    chk("t6_wait_n", cpu_wait_n, 1'b1);
    chk("t6_to_err", to_err, 1'b0);
    // randomized traffic on disjoint CPU and loader address windows
    resp_en = 1'b1;
    resp_min = 0;
    resp_max = 4;
    for (int i = 0; i < 16; i++) begin
      cpu_ref[i] = rd(i);
      ld_ref[i] = 8'h00;
      ldw[i] = 1'b0;
    end
    age = 0;
    cw = 1'b0;
    ca = 0;
    repeat (1500) begin
      tick;
      ld_wr = 1'b0;
      if (cpu_req) begin
        age++;
        if (cpu_wait_n) begin
          if (!cw) chk("t7_rd", cpu_dout, cpu_ref[ca]);
          cpu_req = 1'b0;
        end else if (age > 100) begin
          chk("t7_cpu_stall", 1'b0, 1'b1);
          cpu_req = 1'b0;
        end
      end else if ($urandom_range(3) == 0) begin
        cw = 1'($urandom_range(1));
        ca = $urandom_range(15);
        cpu_we = cw;
        cpu_addr = AW'(ca);
        cpu_din = 8'($urandom);
        if (cw) cpu_ref[ca] = cpu_din;
        cpu_req = 1'b1;
        age = 0;
      end
      if (!ld_wait && $urandom_range(2) == 0) begin
        idx = $urandom_range(15);
        ld_addr = AW'(32'h100 + idx);
        ld_din = 8'($urandom);
        ld_ref[idx] = ld_din;
        ldw[idx] = 1'b1;
        ld_wr = 1'b1;
      end
    end
    cpu_req = 1'b0;
    tick;
    ld_wr = 1'b0;
    n = 0;
    do begin tick; n++; end while ((mem_req || ld_wait) && n < 100);
    for (int i = 0; i < 16; i++) begin
      if (ldw[i]) chk("t7_ld_mem", rd(32'h100 + i), ld_ref[i]);
      chk("t7_cpu_mem", rd(i), cpu_ref[i]);
    end
    chk("t7_stable", stab_err, 0);
    chk("t7_to_err", to_err, 1'b0);
    chk("t7_ovf", ld_ovf, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
